data_mem_responder: RTL and testbench

Byte-addressed data memory that answers the core's load/store interface: MemRead/MemWrite strobes, 9-bit byte address, 32-bit write data and Funct3 access size. Stores commit on the request edge. Loads return sign- or zero-extended data one cycle later with a valid strobe. Misaligned and illegal-size accesses are rejected with an error pulse and never modify memory.

---
 rtl/data_mem_responder.sv | 67 ++++++
 tb/tb_data_mem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressed load/store data memory.
// Stores commit on the request edge; loads answer one cycle later with a valid strobe.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              mem_err,
    output logic [15:0]       access_cnt
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_data_q, rd_data_d, word, shifted, mask, rep;
    logic              rd_valid_q, mem_err_q, ld_legal, st_legal, aligned, err, ld_ok, st_ok;
    logic [15:0]       cnt_q, cnt_d;
    logic [4:0]        sh;

    always_comb begin
        ld_legal  = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_legal  = Funct3 inside {3'b000, 3'b001, 3'b010};
        aligned   = Funct3[1:0] == 2'b10 ? addr[1:0] == 2'b00 : Funct3[1:0] == 2'b01 ? !addr[0] : 1'b1;
        err       = (MemRead && MemWrite) || (MemRead && !ld_legal) || (MemWrite && !st_legal)
                    || ((MemRead || MemWrite) && !aligned);
        ld_ok     = MemRead && !err;
        st_ok     = MemWrite && !err;
        sh        = {addr[1:0], 3'b000};
        word      = mem_q[addr[ADDR_W-1:2]];
        // halfwords are aligned, so one byte-lane shift serves both B and H loads
        shifted   = word >> sh;
        mask      = Funct3[1:0] == 2'b10 ? '1 : Funct3[1:0] == 2'b01 ? 32'h0000_FFFF << sh : 32'h0000_00FF << sh;
        rep       = Funct3[1:0] == 2'b10 ? wr_data : Funct3[1:0] == 2'b01 ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}};
        rd_data_d = err ? '0 : !ld_ok ? rd_data_q
                  : Funct3[1:0] == 2'b10 ? word
                  : Funct3[1:0] == 2'b01 ? {{16{shifted[15] && !Funct3[2]}}, shifted[15:0]}
                  : {{24{shifted[7] && !Funct3[2]}}, shifted[7:0]};
        cnt_d     = cnt_q + 16'(ld_ok || st_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (st_ok) mem_q[addr[ADDR_W-1:2]] <= (word & ~mask) | (rep & mask);
            rd_data_q  <= rd_data_d;
            rd_valid_q <= ld_ok;
            mem_err_q  <= err;
            cnt_q      <= cnt_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign mem_err    = mem_err_q;
    assign access_cnt = cnt_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench with a byte-array reference model checked every cycle.
module tb_data_mem_responder;
    logic        clk = 1'b0, reset = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  Funct3 = '0;
    logic [8:0]  addr = '0;
    logic [31:0] wr_data = '0, rd_data;
    logic        rd_valid, mem_err;
    logic [15:0] access_cnt;

    data_mem_responder dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_err(mem_err), .access_cnt(access_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [7:0]  mm [512];
    logic        exp_valid, exp_err;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 512; i++) mm[i] = 8'h00;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_data  = '0;
        exp_cnt   = '0;
    endfunction

    function automatic void model_step(input logic r, input logic w, input logic [2:0] f,
                                       input logic [8:0] a, input logic [31:0] d);
        int size;
        logic legal;
        logic [31:0] v;
        size = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
        legal = r ? (f inside {0, 1, 2, 4, 5}) : (f inside {0, 1, 2});
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!r && !w) return;
        if ((r && w) || !legal || (a % size) != 0) begin
            exp_err  = 1'b1;
            exp_data = '0;
            return;
        end
        exp_cnt++;
        if (w) begin
            for (int i = 0; i < size; i++) mm[a + i] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mm[a + i];
            if (!f[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            exp_data  = v;
            exp_valid = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
        chk("mem_err", 32'(mem_err), 32'(exp_err));
        chk("access_cnt", 32'(access_cnt), 32'(exp_cnt));
        if (exp_valid || exp_err) chk("rd_data", rd_data, exp_data);
    end

    task automatic req(input logic r, input logic w, input logic [2:0] f,
                       input logic [8:0] a, input logic [31:0] d);
        MemRead = r; MemWrite = w; Funct3 = f; addr = a; wr_data = d;
        @(posedge clk);
        model_step(r, w, f, a, d);
        #1 MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_data", rd_data, 32'h0);
        chk("rst_valid", 32'(rd_valid), 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        chk("rst_cnt", 32'(access_cnt), 32'h0);
        // basic word store/load
        req(0, 1, 3'b010, 9'h010, 32'hDEADBEEF);
        req(1, 0, 3'b010, 9'h010, 32'h0);
        chk("t1_data", rd_data, 32'hDEADBEEF);
        chk("t1_valid", 32'(rd_valid), 32'h1);
        chk("t1_cnt", 32'(access_cnt), 32'd2);
        req(0, 0, 3'b000, 9'h000, 32'h0);
        chk("t1_pulse", 32'(rd_valid), 32'h0);
        // partial stores and byte loads
        req(0, 1, 3'b010, 9'h020, 32'h11223344);
        req(0, 1, 3'b000, 9'h021, 32'h000000AA);
        req(1, 0, 3'b010, 9'h020, 32'h0);
        chk("t2_lw", rd_data, 32'h1122AA44);
        req(1, 0, 3'b000, 9'h021, 32'h0);
        chk("t2_lb", rd_data, 32'hFFFFFFAA);
        req(1, 0, 3'b100, 9'h021, 32'h0);
        chk("t2_lbu", rd_data, 32'h000000AA);
        // halfwords
        req(0, 1, 3'b001, 9'h032, 32'h00008001);
        req(1, 0, 3'b001, 9'h032, 32'h0);
        chk("t3_lh", rd_data, 32'hFFFF8001);
        req(1, 0, 3'b101, 9'h032, 32'h0);
        chk("t3_lhu", rd_data, 32'h00008001);
        req(1, 0, 3'b010, 9'h030, 32'h0);
        chk("t3_lw", rd_data, 32'h80010000);
        chk("t3_cnt", 32'(access_cnt), 32'd11);
        // error cases
        req(1, 0, 3'b010, 9'h013, 32'h0);
        chk("t4_mis_err", 32'(mem_err), 32'h1);
        chk("t4_mis_valid", 32'(rd_valid), 32'h0);
        chk("t4_mis_data", rd_data, 32'h0);
        chk("t4_mis_cnt", 32'(access_cnt), 32'd11);
        req(0, 1, 3'b010, 9'h034, 32'hCAFEF00D);
        req(0, 1, 3'b001, 9'h035, 32'h00001234);
        chk("t4_sh_err", 32'(mem_err), 32'h1);
        req(1, 0, 3'b010, 9'h034, 32'h0);
        chk("t4_sh_mem", rd_data, 32'hCAFEF00D);
        req(1, 1, 3'b010, 9'h010, 32'h0);
        chk("t4_conflict", 32'(mem_err), 32'h1);
        req(0, 1, 3'b100, 9'h040, 32'h12345678);
        chk("t4_st100", 32'(mem_err), 32'h1);
        req(1, 0, 3'b011, 9'h040, 32'h0);
        chk("t4_ld011", 32'(mem_err), 32'h1);
        req(1, 0, 3'b010, 9'h040, 32'h0);
        chk("t4_st100_mem", rd_data, 32'h0);
        chk("t4_cnt", 32'(access_cnt), 32'd14);
        // back-to-back loads
        req(0, 1, 3'b010, 9'h000, 32'h11111111);
        req(0, 1, 3'b010, 9'h004, 32'h22222222);
        req(0, 1, 3'b010, 9'h008, 32'h33333333);
        req(0, 1, 3'b010, 9'h00C, 32'h44444444);
        req(1, 0, 3'b010, 9'h000, 32'h0);
        chk("t5_0", rd_data, 32'h11111111);
        req(1, 0, 3'b010, 9'h004, 32'h0);
        chk("t5_1", rd_data, 32'h22222222);
        req(1, 0, 3'b010, 9'h008, 32'h0);
        chk("t5_2", rd_data, 32'h33333333);
        req(1, 0, 3'b010, 9'h00C, 32'h0);
        chk("t5_3", rd_data, 32'h44444444);
        chk("t5_valid", 32'(rd_valid), 32'h1);
        chk("t5_cnt", 32'(access_cnt), 32'd22);
        // reset lands between a load request and the edge that would answer it
        MemRead = 1'b1; Funct3 = 3'b010; addr = 9'h004;
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1 MemRead = 1'b0;
        @(negedge clk);
        chk("t6_valid_rst", 32'(rd_valid), 32'h0);
        reset = 1'b1;
        req(0, 0, 3'b000, 9'h000, 32'h0);
        chk("t6_valid_rel", 32'(rd_valid), 32'h0);
        chk("t6_cnt", 32'(access_cnt), 32'h0);
        req(1, 0, 3'b010, 9'h004, 32'h0);
        chk("t6_mem4", rd_data, 32'h0);
        req(1, 0, 3'b010, 9'h010, 32'h0);
        chk("t6_mem10", rd_data, 32'h0);
        req(0, 0, 3'b000, 9'h000, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
